// File: rtl/vx_ld_gather_pkg.sv
// rtl/vx_ld_gather_pkg.sv - shared types, widths and lane helpers for the load gather block
package vx_ld_gather_pkg;

    localparam int NW_BITS     = 3;
    localparam int NR_BITS     = 5;
    localparam int NUM_THREADS = 4;
    localparam int DATA_W      = NUM_THREADS * 32;

    // One partially gathered load.
    typedef struct packed {
        logic [NW_BITS-1:0]     wid;
        logic [NR_BITS-1:0]     rd;
        logic [31:0]            pc;
        logic                   wb;
        logic [NUM_THREADS-1:0] tmask;
        logic [DATA_W-1:0]      data;
    } ldg_entry_t;

    // Gather index width: clog2(n), never below 1.
    function automatic int ldg_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Expand a lane mask to a per-bit data mask.
    function automatic logic [DATA_W-1:0] lane_mask(input logic [NUM_THREADS-1:0] m);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            r[i*32 +: 32] = {32{m[i]}};
        end
        return r;
    endfunction

    // Lanes in m take new_d, all other lanes keep old_d.
    function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_d,
                                                     input logic [DATA_W-1:0] new_d,
                                                     input logic [NUM_THREADS-1:0] m);
        return (old_d & ~lane_mask(m)) | (new_d & lane_mask(m));
    endfunction

endpackage

// File: rtl/vx_ld_gather_if.sv
// rtl/vx_ld_gather_if.sv - load commit stream interface (fragment in / merged commit out)
// Ports (modports):
//   master: drives valid, wid, tmask, pc, rd, wb, data, eop; receives ready
//   slave : receives valid, wid, tmask, pc, rd, wb, data, eop; drives ready
interface vx_ld_gather_if;
    import vx_ld_gather_pkg::*;

    logic                   valid;
    logic                   ready;
    logic [NW_BITS-1:0]     wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [31:0]            pc;
    logic [NR_BITS-1:0]     rd;
    logic                   wb;
    logic [DATA_W-1:0]      data;
    logic                   eop;

    modport master (output valid, wid, tmask, pc, rd, wb, data, eop, input ready);
    modport slave  (input valid, wid, tmask, pc, rd, wb, data, eop, output ready);
endinterface

// File: rtl/vx_ld_gather_entry.sv
// rtl/vx_ld_gather_entry.sv - one gather slot: storage, {wid,rd} match and lane merge
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_frag       : incoming fragment fields
//   i_alloc      : load a new load from i_frag (unused lanes zeroed)
//   i_upd        : merge i_frag into the stored load
//   i_free       : release the slot
//   o_valid      : slot holds a partial load
//   o_hit        : slot is valid and matches i_frag {wid,rd}
//   o_tmask      : lanes gathered so far
//   o_merged     : stored load merged with i_frag
module vx_ld_gather_entry
    import vx_ld_gather_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  ldg_entry_t             i_frag,
    input  logic                   i_alloc,
    input  logic                   i_upd,
    input  logic                   i_free,
    output logic                   o_valid,
    output logic                   o_hit,
    output logic [NUM_THREADS-1:0] o_tmask,
    output ldg_entry_t             o_merged
);

    logic       r_valid;
    ldg_entry_t r_ent;

    assign o_valid = r_valid;
    assign o_tmask = r_ent.tmask;
    assign o_hit   = r_valid && (r_ent.wid == i_frag.wid) && (r_ent.rd == i_frag.rd);

    always_comb begin
        o_merged       = r_ent;
        o_merged.tmask = r_ent.tmask | i_frag.tmask;
        o_merged.data  = lane_merge(r_ent.data, i_frag.data, i_frag.tmask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_ent   <= '0;
        end else if (i_alloc) begin
            r_valid    <= 1'b1;
            r_ent      <= i_frag;
            r_ent.data <= i_frag.data & lane_mask(i_frag.tmask);
        end else if (i_upd) begin
            r_ent.tmask <= o_merged.tmask;
            r_ent.data  <= o_merged.data;
        end else if (i_free) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/vx_ld_gather.sv
// rtl/vx_ld_gather.sv - merges LSU load fragments into one full-warp commit per load
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   in_if      : fragment stream from the LSU (slave)
//   out_if     : merged commit stream to writeback (master), eop always 1
//   full       : every gather slot holds a partial load
module vx_ld_gather
    import vx_ld_gather_pkg::*;
#(
    parameter int CORE_ID     = 0,
    parameter int GATHER_SIZE = 4
) (
    input  logic            clk,
    input  logic            reset,
    vx_ld_gather_if.slave   in_if,
    vx_ld_gather_if.master  out_if,
    output logic            full
);

    localparam int IDX_W = ldg_idx_w(GATHER_SIZE);

    ldg_entry_t             w_frag;
    logic [GATHER_SIZE-1:0] w_valid;
    logic [GATHER_SIZE-1:0] w_hit;
    logic [NUM_THREADS-1:0] w_old_tmask [GATHER_SIZE];
    ldg_entry_t             w_merged    [GATHER_SIZE];
    logic [IDX_W-1:0]       w_hit_idx;
    logic [IDX_W-1:0]       w_free_idx;
    logic                   w_hit_any;
    logic                   w_eop_like;
    logic                   w_out_free;
    logic                   w_fire;
    logic                   w_fire_eop;
    logic                   w_fire_upd;
    logic                   w_fire_alloc;

    logic                   r_out_valid;
    ldg_entry_t             r_out;

    always_comb begin
        w_frag       = '0;
        w_frag.wid   = in_if.wid;
        w_frag.rd    = in_if.rd;
        w_frag.pc    = in_if.pc;
        w_frag.wb    = in_if.wb;
        w_frag.tmask = in_if.tmask;
        w_frag.data  = in_if.data;
    end

    for (genvar g = 0; g < GATHER_SIZE; g++) begin : g_entry
        vx_ld_gather_entry u_entry (
            .clk      (clk),
            .reset    (reset),
            .i_frag   (w_frag),
            .i_alloc  (w_fire_alloc && (w_free_idx == IDX_W'(g))),
            .i_upd    (w_fire_upd && w_hit[g]),
            .i_free   (w_fire_eop && w_hit[g]),
            .o_valid  (w_valid[g]),
            .o_hit    (w_hit[g]),
            .o_tmask  (w_old_tmask[g]),
            .o_merged (w_merged[g])
        );
    end

    // Descending scan so the lowest index wins for the free slot.
    always_comb begin
        w_hit_idx  = '0;
        w_free_idx = '0;
        for (int i = GATHER_SIZE - 1; i >= 0; i--) begin
            if (w_hit[i])
                w_hit_idx = IDX_W'(i);
            if (!w_valid[i])
                w_free_idx = IDX_W'(i);
        end
    end

    assign full       = &w_valid;
    assign w_hit_any  = |w_hit;
    // A no-writeback fragment has nothing to gather, so it commits immediately.
    assign w_eop_like = in_if.eop | ~in_if.wb;
    assign w_out_free = ~r_out_valid | out_if.ready;

    assign in_if.ready = in_if.valid ? (w_eop_like ? w_out_free : (w_hit_any | ~full))
                                     : (w_out_free & ~full);

    assign w_fire       = in_if.valid & in_if.ready;
    assign w_fire_eop   = w_fire & w_eop_like;
    assign w_fire_upd   = w_fire & ~w_eop_like & w_hit_any;
    assign w_fire_alloc = w_fire & ~w_eop_like & ~w_hit_any;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_fire_eop) begin
            r_out_valid <= 1'b1;
            r_out       <= w_hit_any ? w_merged[w_hit_idx] : w_frag;
        end else if (out_if.ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_if.valid = r_out_valid;
    assign out_if.wid   = r_out.wid;
    assign out_if.rd    = r_out.rd;
    assign out_if.pc    = r_out.pc;
    assign out_if.wb    = r_out.wb;
    assign out_if.tmask = r_out.tmask;
    assign out_if.data  = r_out.data;
    assign out_if.eop   = 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(w_hit))
                else $error("vx_ld_gather[%0d]: multiple gather hits %b", CORE_ID, w_hit);
            if (w_fire && w_hit_any)
                assert ((w_old_tmask[w_hit_idx] & in_if.tmask) == '0)
                    else $error("vx_ld_gather[%0d]: lane overlap wid=%0d rd=%0d",
                                CORE_ID, in_if.wid, in_if.rd);
        end
    end

endmodule

// File: tb/tb_vx_ld_gather.sv
// tb/tb_vx_ld_gather.sv - directed self-checking bench for vx_ld_gather
module tb_vx_ld_gather;
    import vx_ld_gather_pkg::*;

    logic clk;
    logic reset;
    logic full;
    int   n_checks;
    int   n_fail;
    int   n_commits;
    int   c0;

    vx_ld_gather_if in_if ();
    vx_ld_gather_if out_if ();

    vx_ld_gather #(
        .CORE_ID     (0),
        .GATHER_SIZE (4)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .in_if  (in_if),
        .out_if (out_if),
        .full   (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && out_if.valid && out_if.ready)
            n_commits <= n_commits + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] d4(input logic [31:0] l3, input logic [31:0] l2,
                                        input logic [31:0] l1, input logic [31:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic drive(input int wid, input int rd, input logic [3:0] tmask,
                         input logic [127:0] data, input logic eop, input logic wb);
        in_if.valid = 1'b1;
        in_if.wid   = NW_BITS'(wid);
        in_if.rd    = NR_BITS'(rd);
        in_if.pc    = 32'h1000 + 32'(wid * 16 + rd);
        in_if.tmask = tmask;
        in_if.data  = data;
        in_if.eop   = eop;
        in_if.wb    = wb;
    endtask

    // Starts and ends on a falling edge; waits (bounded) for acceptance.
    task automatic frag(input int wid, input int rd, input logic [3:0] tmask,
                        input logic [127:0] data, input logic eop, input logic wb);
        int k;
        drive(wid, rd, tmask, data, eop, wb);
        #1;
        k = 0;
        while (!in_if.ready && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!in_if.ready)
            check("frag_accept_timeout", 128'(in_if.ready), 128'd1);
        @(posedge clk);
        @(negedge clk);
        in_if.valid = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        n_commits    = 0;
        reset        = 1'b1;
        in_if.valid  = 1'b0;
        in_if.wid    = '0;
        in_if.rd     = '0;
        in_if.pc     = '0;
        in_if.tmask  = '0;
        in_if.data   = '0;
        in_if.eop    = 1'b0;
        in_if.wb     = 1'b1;
        out_if.ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 128'(out_if.valid), 128'd0);
        check("rst_full", 128'(full), 128'd0);
        check("rst_out_tmask", 128'(out_if.tmask), 128'd0);
        check("rst_out_data", out_if.data, 128'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("idle_in_ready", 128'(in_if.ready), 128'd1);

        // 1: single eop fragment passes straight through
        frag(1, 5, 4'b1111, d4(4, 3, 2, 1), 1'b1, 1'b1);
        check("t1_out_valid", 128'(out_if.valid), 128'd1);
        check("t1_out_tmask", 128'(out_if.tmask), 128'hf);
        check("t1_out_data", out_if.data, d4(4, 3, 2, 1));
        check("t1_out_wid_rd", 128'({out_if.wid, out_if.rd}), 128'({3'd1, 5'd5}));
        check("t1_out_eop", 128'(out_if.eop), 128'd1);
        check("t1_full", 128'(full), 128'd0);
        @(negedge clk);
        check("t1_drained", 128'(out_if.valid), 128'd0);

        // wb=0 without eop behaves as eop
        frag(3, 4, 4'b0010, d4(0, 0, 32'h77, 0), 1'b0, 1'b0);
        check("wb0_out_valid", 128'(out_if.valid), 128'd1);
        check("wb0_out_wb", 128'(out_if.wb), 128'd0);
        check("wb0_out_tmask", 128'(out_if.tmask), 128'h2);
        @(negedge clk);

        // 2: two fragments merged
        frag(2, 7, 4'b0011, d4(0, 0, 32'hB, 32'hA), 1'b0, 1'b1);
        check("t2_no_commit", 128'(out_if.valid), 128'd0);
        frag(2, 7, 4'b1100, d4(32'hD, 32'hC, 0, 0), 1'b1, 1'b1);
        check("t2_out_valid", 128'(out_if.valid), 128'd1);
        check("t2_out_tmask", 128'(out_if.tmask), 128'hf);
        check("t2_out_data", out_if.data, d4(32'hD, 32'hC, 32'hB, 32'hA));
        @(negedge clk);

        // 3: interleaved loads, non-carried lanes hold garbage on the wire
        c0 = n_commits;
        frag(0, 3, 4'b0001, d4(32'hEE, 32'hEE, 32'hEE, 32'hA0), 1'b0, 1'b1);
        frag(1, 3, 4'b0010, d4(32'hFF, 32'hFF, 32'hB1, 32'hFF), 1'b0, 1'b1);
        frag(0, 3, 4'b1110, d4(32'hA3, 32'hA2, 32'hA1, 32'hEE), 1'b1, 1'b1);
        check("t3a_wid", 128'(out_if.wid), 128'd0);
        check("t3a_tmask", 128'(out_if.tmask), 128'hf);
        check("t3a_data", out_if.data, d4(32'hA3, 32'hA2, 32'hA1, 32'hA0));
        frag(1, 3, 4'b0100, d4(32'hFF, 32'hB2, 32'hFF, 32'hFF), 1'b1, 1'b1);
        check("t3b_wid", 128'(out_if.wid), 128'd1);
        check("t3b_tmask", 128'(out_if.tmask), 128'h6);
        check("t3b_data", out_if.data, d4(0, 32'hB2, 32'hB1, 0));
        @(negedge clk);
        check("t3_commit_count", 128'(n_commits - c0), 128'd2);

        // 4: fill all slots, fifth stalls, eop frees slot 0
        for (int i = 0; i < 4; i++) begin
            frag(i, 1, 4'b0001, d4(0, 0, 0, 32'h10 + 32'(i)), 1'b0, 1'b1);
            if (i == 2)
                check("t4_not_full_3", 128'(full), 128'd0);
        end
        check("t4_full", 128'(full), 128'd1);
        drive(4, 1, 4'b0001, d4(0, 0, 0, 32'h14), 1'b0, 1'b1);
        #1;
        check("t4_fifth_stall", 128'(in_if.ready), 128'd0);
        @(negedge clk);
        #1;
        check("t4_fifth_stall2", 128'(in_if.ready), 128'd0);
        in_if.valid = 1'b0;
        frag(0, 1, 4'b1110, d4(3, 2, 1, 0), 1'b1, 1'b1);
        check("t4_e0_tmask", 128'(out_if.tmask), 128'hf);
        check("t4_e0_data", out_if.data, d4(3, 2, 1, 32'h10));
        check("t4_freed", 128'(full), 128'd0);
        drive(4, 1, 4'b0001, d4(0, 0, 0, 32'h14), 1'b0, 1'b1);
        #1;
        check("t4_fifth_ready", 128'(in_if.ready), 128'd1);
        frag(4, 1, 4'b0001, d4(0, 0, 0, 32'h14), 1'b0, 1'b1);
        check("t4_full_again", 128'(full), 128'd1);
        for (int i = 1; i < 5; i++) begin
            frag(i, 1, 4'b1000, d4(32'h99, 0, 0, 0), 1'b1, 1'b1);
            check("t4_drain_data", out_if.data, d4(32'h99, 0, 0, 32'h10 + 32'(i)));
        end
        check("t4_empty", 128'(full), 128'd0);
        @(negedge clk);

        // 5: backpressure
        out_if.ready = 1'b0;
        frag(5, 2, 4'b1111, d4(8, 7, 6, 5), 1'b1, 1'b1);
        check("t5_held_valid", 128'(out_if.valid), 128'd1);
        drive(6, 2, 4'b1111, d4(32'hC, 32'hB, 32'hA, 9), 1'b1, 1'b1);
        #1;
        check("t5_in_blocked", 128'(in_if.ready), 128'd0);
        @(negedge clk);
        check("t5_stable_wid", 128'(out_if.wid), 128'd5);
        check("t5_stable_data", out_if.data, d4(8, 7, 6, 5));
        c0 = n_commits;
        out_if.ready = 1'b1;
        #1;
        check("t5_in_unblocked", 128'(in_if.ready), 128'd1);
        @(negedge clk);
        in_if.valid = 1'b0;
        check("t5_new_wid", 128'(out_if.wid), 128'd6);
        check("t5_new_valid", 128'(out_if.valid), 128'd1);
        check("t5_old_drained", 128'(n_commits - c0), 128'd1);
        @(negedge clk);

        // 6: reset discards partial entries
        frag(7, 9, 4'b0011, d4(0, 0, 2, 1), 1'b0, 1'b1);
        frag(6, 9, 4'b0001, d4(0, 0, 0, 5), 1'b0, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_out_valid", 128'(out_if.valid), 128'd0);
        check("t6_full", 128'(full), 128'd0);
        reset = 1'b0;
        @(negedge clk);
        frag(7, 9, 4'b0100, d4(0, 32'hC, 0, 0), 1'b1, 1'b1);
        check("t6_tmask", 128'(out_if.tmask), 128'h4);
        check("t6_data", out_if.data, d4(0, 32'hC, 0, 0));
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_ld_gather.md
Name: vx_ld_gather

Overview:
- Sits directly downstream of the LSU load-commit port, between the LSU and the writeback/commit arbiter.
- The LSU returns a load as one or more partial fragments. Each fragment carries a subset of lanes; the last one is flagged eop.
- This block merges all fragments of one load (key = wid + rd) into a single full-warp commit, so writeback sees exactly one commit per load instruction.
- Fragments of different loads may interleave freely.

Parameters:
- CORE_ID, 0, core index; used only in debug prints.
- GATHER_SIZE, 4, number of concurrent partially-gathered loads; must be ≥1; index width is clog2(GATHER_SIZE), minimum 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fragment valid
- in_ready  out  1  fragment accepted when in_valid & in_ready
- in_wid  in  `NW_BITS  warp id
- in_tmask  in  `NUM_THREADS  lanes carried by this fragment
- in_pc  in  32  load PC
- in_rd  in  `NR_BITS  destination register
- in_wb  in  1  writeback enable
- in_data  in  `NUM_THREADS*32  per-lane data; only tmask lanes meaningful
- in_eop  in  1  last fragment of this load
- out_valid  out  1  merged commit valid
- out_ready  in  1  downstream accept
- out_wid  out  `NW_BITS  warp id
- out_tmask  out  `NUM_THREADS  OR of all fragment tmasks
- out_pc  out  32  PC
- out_rd  out  `NR_BITS  destination register
- out_wb  out  1  writeback enable
- out_data  out  `NUM_THREADS*32  merged lane data
- out_eop  out  1  constant 1
- full  out  1  all gather entries valid

Behaviour:
- State
  - GATHER_SIZE entries, each {valid, wid, rd, pc, wb, tmask, data}.
  - One output holding register.
- Reset: all entry valids = 0, out_valid = 0; other out_* = 0; full = 0.
- Output slot free: out_free = ~out_valid | out_ready.
- Match
  - Hit = a valid entry with equal wid and rd, computed combinationally.
  - At most one hit can exist. Multiple hits are an assertion error.
- Non-eop fragment, hit
  - Entry.tmask |= in_tmask.
  - Entry data lanes in in_tmask are overwritten.
  - Always accepted; no dependence on out_free.
- Non-eop fragment, miss
  - Allocates the lowest-index invalid entry, loading tmask/data/pc/wb.
  - Entry lanes not in in_tmask are zeroed.
  - If no entry is free: in_ready = 0.
- eop fragment
  - Requires out_free; otherwise in_ready = 0.
  - Hit: output register <= entry merged with the fragment (same merge rule); entry valid <= 0.
  - Miss (single-fragment load): fragment passes straight to the output register.
- in_wb = 0 fragments: treated as eop regardless of in_eop; never allocate.
- Latency
  - out_valid asserts the cycle after the eop fragment is accepted.
  - Throughput is 1 commit/cycle while out_ready = 1.
- Output register
  - Loads when an eop fragment fires.
  - Otherwise out_valid clears when out_ready & out_valid.
  - Holds stable while out_valid & ~out_ready.
- in_ready = in_valid ? (eop_like ? out_free : (hit | ~full)) : (out_free & ~full); combinational.
- Entry freed by eop in cycle N is allocatable from cycle N+1 (no same-cycle reuse).
- Lane overlap: a fragment lane already set in the entry's tmask is an assertion error in simulation; data is overwritten.
- Reset mid-gather: all partial entries are discarded; no commit is emitted.
- full = &entry.valid, registered view of current state.

Decomposition:
- Shared package/defines: gather-entry struct {wid, rd, pc, wb, tmask, data}; GATHER index width macro.
  - `NW_BITS, `NR_BITS, `NUM_THREADS come from VX_define.vh.
- One natural sub-module: vx_ld_gather_entry, a single entry register with match compare and merge logic, instantiated GATHER_SIZE times.
- Top level holds the lowest-free priority encoder, hit one-hot-to-index, and the output register.

Test Plan:
All scenarios use NUM_THREADS = 4 and GATHER_SIZE = 4.
1. Single eop fragment, wid=1 rd=5 tmask=1111 data={4,3,2,1}, out_ready=1 -> next cycle out_valid=1, tmask=1111, data={4,3,2,1}; no entry allocated, full=0.
2. Two fragments wid=2 rd=7: tmask=0011 data lanes0/1=A/B (no eop), then tmask=1100 lanes2/3=C/D eop -> one commit, tmask=1111, data={D,C,B,A}; entry freed.
3. Interleave wid=0 rd=3 frag1, wid=1 rd=3 frag1, wid=0 rd=3 eop, wid=1 rd=3 eop -> exactly two commits in eop order, each carrying only its own lanes.
4. Five non-eop fragments with distinct {wid,rd} -> first four accepted, full=1, fifth stalls with in_ready=0. Eop for entry 0 -> commit emitted; fifth is accepted the following cycle into entry 0.
5. Backpressure: out_ready=0 with out_valid=1, eop arriving -> in_ready=0, outputs stable. Raising out_ready -> old commit drains and new eop is accepted in the same cycle.
6. Reset asserted with two partial entries outstanding -> out_valid=0 and full=0 after reset. A later eop for the same {wid,rd} passes through with its tmask only.
